// File: rtl/mux41_rr_sched.sv
// mux41_rr_sched: round-robin owner scheduler for a 4:1 one-hot mux.
// Ports: CLK, RST_N (async low), EN, REQ[3:0] in; S0..S3, GNT_ID, GNT_CHG, BUSY out.
module mux41_rr_sched #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [3:0] REQ,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic [1:0] GNT_ID,
    output logic       GNT_CHG,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sel_q, sel_d;
    logic [1:0]       id_q, id_d;
    logic             chg_q, chg_d;
    logic             busy_q, busy_d;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    // First requester at or after the pointer, wrapping 3 -> 0.
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && REQ[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        id_d    = id_q;
        chg_d   = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            ST_GRANT: begin
                // Owner dropped its request or used up its tenure:
                // force one all-zero cycle before anyone else gets the mux.
                if (!REQ[id_q] || cnt_q == CNT_LAST) begin
                    state_d = ST_GAP;
                    ptr_d   = id_q + 2'd1;
                    cnt_d   = '0;
                    sel_d   = 4'b0000;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (EN && |REQ) begin
                    state_d = ST_GRANT;
                    id_d    = win;
                    sel_d   = 4'b0001 << win;
                    cnt_d   = '0;
                    chg_d   = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    sel_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            sel_q   <= 4'b0000;
            id_q    <= 2'd0;
            chg_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            id_q    <= id_d;
            chg_q   <= chg_d;
            busy_q  <= busy_d;
        end
    end

    assign S0      = sel_q[0];
    assign S1      = sel_q[1];
    assign S2      = sel_q[2];
    assign S3      = sel_q[3];
    assign GNT_ID  = id_q;
    assign GNT_CHG = chg_q;
    assign BUSY    = busy_q;

endmodule
